// File: rtl/algo_8r8w1p_rdbuf.sv
// +--------------------------------------------------------------------------+
// | algo_8r8w1p_rdbuf: credit-gated per-port read return buffer placed        |
// | behind the 8r8w 1-port memory wrapper. Optional: ALGO_RDBUF_ECCCNT_EN.    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module algo_8r8w1p_rdbuf #(
  parameter int NUMRDPT = 8,
  parameter int WIDTH   = 64,
  parameter int BITADDR = 13,
  parameter int BITPADR = 15,
  parameter int FIFODEP = 4,
  parameter int BITFIFO = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mem_ready,
  input  logic [NUMRDPT-1:0]         cl_read,
  input  logic [NUMRDPT*BITADDR-1:0] cl_rd_adr,
  output logic [NUMRDPT-1:0]         cl_rdy,
  output logic [NUMRDPT-1:0]         read,
  output logic [NUMRDPT*BITADDR-1:0] rd_adr,
  input  logic [NUMRDPT-1:0]         rd_vld,
  input  logic [NUMRDPT*WIDTH-1:0]   rd_dout,
  input  logic [NUMRDPT-1:0]         rd_serr,
  input  logic [NUMRDPT-1:0]         rd_derr,
  input  logic [NUMRDPT*BITPADR-1:0] rd_padr,
  output logic [NUMRDPT-1:0]         o_vld,
  input  logic [NUMRDPT-1:0]         o_rdy,
  output logic [NUMRDPT*WIDTH-1:0]   o_dout,
  output logic [NUMRDPT-1:0]         o_serr,
  output logic [NUMRDPT-1:0]         o_derr,
  output logic [NUMRDPT*BITPADR-1:0] o_padr,
  output logic [NUMRDPT-1:0]         err_spur
`ifdef ALGO_RDBUF_ECCCNT_EN
  ,
  output logic [15:0]                serr_cnt,
  output logic [15:0]                derr_cnt
`endif
);

  localparam int                 ENTW = WIDTH + 2 + BITPADR;
  localparam logic [BITFIFO+1:0] DEPW = (BITFIFO+2)'(FIFODEP);
  localparam logic [BITFIFO:0]   FULL = (BITFIFO+1)'(FIFODEP);

  assign rd_adr = cl_rd_adr;

  for (genvar i = 0; i < NUMRDPT; i++) begin : g_port
    logic [BITFIFO:0]   occ_q, occ_d, infl_q, infl_d;
    logic [BITFIFO-1:0] wptr_q, rptr_q;
    logic [ENTW-1:0]    mem_q [FIFODEP];
    logic [ENTW-1:0]    entry, head;
    logic               spur_q, rdy, issue, ret_ok, push, pop, vld;

    assign entry = {rd_dout[i*WIDTH +: WIDTH], rd_serr[i], rd_derr[i],
                    rd_padr[i*BITPADR +: BITPADR]};
    assign head  = mem_q[rptr_q];

    always_comb begin
      vld    = (occ_q != '0);
      // Credits: buffered plus outstanding entries never exceed the FIFO depth.
      rdy    = mem_ready & (({1'b0, occ_q} + {1'b0, infl_q}) < DEPW);
      issue  = cl_read[i] & rdy;
      ret_ok = rd_vld[i] & (infl_q != '0);
      push   = rd_vld[i] & (occ_q != FULL);
      pop    = vld & o_rdy[i];
      infl_d = infl_q;
      if (issue & ~ret_ok)      infl_d = infl_q + 1'b1;
      else if (~issue & ret_ok) infl_d = infl_q - 1'b1;
      occ_d = occ_q;
      if (push & ~pop)      occ_d = occ_q + 1'b1;
      else if (~push & pop) occ_d = occ_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        occ_q  <= '0;
        infl_q <= '0;
        wptr_q <= '0;
        rptr_q <= '0;
        spur_q <= 1'b0;
        for (int k = 0; k < FIFODEP; k++) mem_q[k] <= '0;
      end else begin
        occ_q  <= occ_d;
        infl_q <= infl_d;
        if (rd_vld[i] && infl_q == '0) spur_q <= 1'b1;
        if (push) begin
          mem_q[wptr_q] <= entry;
          wptr_q        <= wptr_q + 1'b1;
        end
        if (pop) rptr_q <= rptr_q + 1'b1;
      end
    end

    assign cl_rdy[i]                     = rdy;
    assign read[i]                       = issue;
    assign o_vld[i]                      = vld;
    assign err_spur[i]                   = spur_q;
    assign o_dout[i*WIDTH +: WIDTH]      = head[ENTW-1 -: WIDTH];
    assign o_serr[i]                     = head[BITPADR+1];
    assign o_derr[i]                     = head[BITPADR];
    assign o_padr[i*BITPADR +: BITPADR]  = head[BITPADR-1:0];
  end

`ifdef ALGO_RDBUF_ECCCNT_EN
  localparam int CW = $clog2(NUMRDPT + 1);
  logic [CW-1:0] serr_pc, derr_pc;
  logic [16:0]   serr_sum, derr_sum;
  logic [15:0]   serr_cnt_q, derr_cnt_q;

  always_comb begin
    serr_pc = '0;
    derr_pc = '0;
    for (int k = 0; k < NUMRDPT; k++) begin
      serr_pc = serr_pc + CW'(rd_vld[k] & rd_serr[k]);
      derr_pc = derr_pc + CW'(rd_vld[k] & rd_derr[k]);
    end
    serr_sum = {1'b0, serr_cnt_q} + 17'(serr_pc);
    derr_sum = {1'b0, derr_cnt_q} + 17'(derr_pc);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      serr_cnt_q <= '0;
      derr_cnt_q <= '0;
    end else begin
      serr_cnt_q <= serr_sum[16] ? 16'hFFFF : serr_sum[15:0];
      derr_cnt_q <= derr_sum[16] ? 16'hFFFF : derr_sum[15:0];
    end
  end

  assign serr_cnt = serr_cnt_q;
  assign derr_cnt = derr_cnt_q;
`else
  // ECC event counters are not built in this configuration.
`endif

endmodule

`default_nettype wire

// File: tb/tb_algo_8r8w1p_rdbuf.sv
// Testbench for algo_8r8w1p_rdbuf: the bench acts as the memory wrapper and
// client, with a per-port scoreboard of returned entries.
`default_nettype none

module tb_algo_8r8w1p_rdbuf;
  localparam int NP = 8, W = 64, BA = 13, BP = 15, EW = W + 2 + BP;

  logic              clk = 1'b0, rst = 1'b0, mem_ready = 1'b1;
  logic [NP-1:0]     cl_read = '0, cl_rdy, read, rd_vld = '0, rd_serr = '0, rd_derr = '0;
  logic [NP*BA-1:0]  cl_rd_adr = '0, rd_adr;
  logic [NP*W-1:0]   rd_dout = '0, o_dout;
  logic [NP*BP-1:0]  rd_padr = '0, o_padr;
  logic [NP-1:0]     o_vld, o_rdy = '0, o_serr, o_derr, err_spur;
`ifdef ALGO_RDBUF_ECCCNT_EN
  logic [15:0]       serr_cnt, derr_cnt;
`endif

  int vectors = 0, miscompares = 0;
  logic [EW-1:0] sb [NP][$];

  algo_8r8w1p_rdbuf dut (
    .clk(clk), .rst(rst), .mem_ready(mem_ready), .cl_read(cl_read), .cl_rd_adr(cl_rd_adr),
    .cl_rdy(cl_rdy), .read(read), .rd_adr(rd_adr), .rd_vld(rd_vld), .rd_dout(rd_dout),
    .rd_serr(rd_serr), .rd_derr(rd_derr), .rd_padr(rd_padr), .o_vld(o_vld), .o_rdy(o_rdy),
    .o_dout(o_dout), .o_serr(o_serr), .o_derr(o_derr), .o_padr(o_padr), .err_spur(err_spur)
`ifdef ALGO_RDBUF_ECCCNT_EN
    , .serr_cnt(serr_cnt), .derr_cnt(derr_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_ret(input int p, input logic [W-1:0] d, input logic s, input logic e,
                         input logic [BP-1:0] a, input bit exp_push);
    rd_vld[p] = 1'b1;
    rd_dout[p*W +: W] = d;
    rd_serr[p] = s;
    rd_derr[p] = e;
    rd_padr[p*BP +: BP] = a;
    if (exp_push) sb[p].push_back({d, s, e, a});
  endtask

  task automatic clr_ret();
    rd_vld = '0; rd_dout = '0; rd_serr = '0; rd_derr = '0; rd_padr = '0;
  endtask

  task automatic issue_n(input int p, input int n);
    for (int k = 0; k < n; k++) begin
      cl_read[p] = 1'b1;
      tick();
    end
    cl_read[p] = 1'b0;
  endtask

  // Samples the head of port p, pops it, and returns the scoreboard's expectation.
  task automatic do_pop(input int p, output logic v, output logic [EW-1:0] got,
                        output logic [EW-1:0] exp);
    v   = o_vld[p];
    got = {o_dout[p*W +: W], o_serr[p], o_derr[p], o_padr[p*BP +: BP]};
    exp = (sb[p].size() > 0) ? sb[p].pop_front() : 'x;
    o_rdy[p] = 1'b1;
    tick();
    o_rdy[p] = 1'b0;
  endtask

  task automatic test_reset();
    cl_read = '1;
    #1;
    vectors++;
    if (o_vld !== '0 || err_spur !== '0 || o_dout !== '0 || o_padr !== '0 ||
        o_serr !== '0 || o_derr !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: vld=%h spur=%h serr=%h derr=%h want all zero",
               o_vld, err_spur, o_serr, o_derr);
    end
    vectors++;
    if (cl_rdy !== 8'hFF || read !== 8'hFF) begin
      miscompares++;
      $display("FAIL reset_credit: cl_rdy=%h read=%h want ff ff", cl_rdy, read);
    end
    cl_read = '0;
    @(negedge clk) rst = 1'b1;
    tick();
  endtask

  task automatic test_credit();
    logic v; logic [EW-1:0] g, e; logic [BA-1:0] ea;
    for (int k = 0; k < 4; k++) begin
      cl_read[0] = 1'b1;
      ea = BA'(32'h100 + k);
      cl_rd_adr[BA-1:0] = ea;
      #1;
      vectors++;
      if (read[0] !== 1'b1 || rd_adr[BA-1:0] !== ea) begin
        miscompares++;
        $display("FAIL credit_issue%0d: read=%b adr=%h want 1 %h", k, read[0], rd_adr[BA-1:0], ea);
      end
      tick();
    end
    vectors++;
    if (cl_rdy[0] !== 1'b0 || read[0] !== 1'b0 || cl_rdy[7:1] !== 7'h7F) begin
      miscompares++;
      $display("FAIL credit_exhausted: cl_rdy=%h read0=%b want fe 0", cl_rdy, read[0]);
    end
    cl_read[0] = 1'b0;
    o_rdy[0] = 1'b1;
    tick();
    o_rdy[0] = 1'b0;
    drv_ret(0, 64'hA5, 1'b0, 1'b0, 15'h0010, 1);
    #1;
    vectors++;
    if (o_vld[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL no_bypass: o_vld0=%b want 0", o_vld[0]);
    end
    tick();
    vectors++;
    if (o_vld[0] !== 1'b1 || o_dout[63:0] !== 64'hA5) begin
      miscompares++;
      $display("FAIL latency: o_vld0=%b dout=%h want 1 a5", o_vld[0], o_dout[63:0]);
    end
    for (int k = 1; k < 4; k++) begin
      drv_ret(0, 64'hA5 + 64'(k), k[0], k[1], 15'(16 + k), 1);
      tick();
    end
    clr_ret();
    for (int k = 0; k < 4; k++) begin
      do_pop(0, v, g, e);
      vectors++;
      if ({v, g} !== {1'b1, e}) begin
        miscompares++;
        $display("FAIL credit_pop%0d: vld=%b entry=%h want 1 %h", k, v, g, e);
      end
    end
    vectors++;
    if (cl_rdy[0] !== 1'b1 || o_vld[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL credit_return: cl_rdy0=%b o_vld0=%b want 1 0", cl_rdy[0], o_vld[0]);
    end
  endtask

  task automatic test_back_to_back();
    logic v; logic [EW-1:0] g, e;
    issue_n(3, 3);
    drv_ret(3, 64'h3000, 1'b0, 1'b1, 15'h300, 1); tick();
    drv_ret(3, 64'h3001, 1'b1, 1'b0, 15'h301, 1); tick();
    cl_read[3] = 1'b1;
    drv_ret(3, 64'h3002, 1'b1, 1'b1, 15'h302, 1);
    #1;
    vectors++;
    if (read[3] !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_issue: read3=%b want 1", read[3]);
    end
    do_pop(3, v, g, e);
    cl_read[3] = 1'b0;
    clr_ret();
    vectors++;
    if ({v, g} !== {1'b1, e}) begin
      miscompares++;
      $display("FAIL b2b_pop: vld=%b entry=%h want 1 %h", v, g, e);
    end
    vectors++;
    if (cl_rdy[3] !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_credit_one: cl_rdy3=%b want 1", cl_rdy[3]);
    end
    issue_n(3, 1);
    vectors++;
    if (cl_rdy[3] !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_credit_zero: cl_rdy3=%b want 0", cl_rdy[3]);
    end
    drv_ret(3, 64'h3003, 1'b0, 1'b0, 15'h303, 1); tick();
    drv_ret(3, 64'h3004, 1'b0, 1'b0, 15'h304, 1); tick();
    clr_ret();
    for (int k = 0; k < 4; k++) begin
      do_pop(3, v, g, e);
      vectors++;
      if ({v, g} !== {1'b1, e}) begin
        miscompares++;
        $display("FAIL b2b_order%0d: vld=%b entry=%h want 1 %h", k, v, g, e);
      end
    end
    vectors++;
    if (err_spur[3] !== 1'b0 || cl_rdy[3] !== 1'b1 || o_vld[3] !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_final: spur3=%b cl_rdy3=%b o_vld3=%b want 0 1 0",
               err_spur[3], cl_rdy[3], o_vld[3]);
    end
  endtask

  task automatic test_spurious();
    logic v; logic [EW-1:0] g, e;
    drv_ret(5, 64'h5555, 1'b1, 1'b0, 15'h055, 1);
    tick();
    clr_ret();
    vectors++;
    if (err_spur !== 8'h20) begin
      miscompares++;
      $display("FAIL spur_flag: err_spur=%h want 20", err_spur);
    end
    do_pop(5, v, g, e);
    vectors++;
    if ({v, g} !== {1'b1, e}) begin
      miscompares++;
      $display("FAIL spur_data: vld=%b entry=%h want 1 %h", v, g, e);
    end
    cl_read[5] = 1'b1;
    #1;
    vectors++;
    if (read[5] !== 1'b1) begin
      miscompares++;
      $display("FAIL spur_no_underflow: read5=%b want 1", read[5]);
    end
    tick();
    cl_read[5] = 1'b0;
    drv_ret(5, 64'h5AA5, 1'b0, 1'b0, 15'h056, 1);
    tick();
    clr_ret();
    do_pop(5, v, g, e);
    vectors++;
    if ({v, g, err_spur[5]} !== {1'b1, e, 1'b1}) begin
      miscompares++;
      $display("FAIL spur_sticky: vld=%b entry=%h spur5=%b want 1 %h 1", v, g, err_spur[5], e);
    end
    issue_n(6, 4);
    for (int k = 0; k < 4; k++) begin
      drv_ret(6, 64'h6000 + 64'(k), 1'b0, 1'b0, 15'(32'h600 + k), 1);
      tick();
    end
    drv_ret(6, 64'hDEAD, 1'b1, 1'b1, 15'h7FF, 0);
    tick();
    clr_ret();
    vectors++;
    if (err_spur[6] !== 1'b1 || cl_rdy[6] !== 1'b0) begin
      miscompares++;
      $display("FAIL spur_full: spur6=%b cl_rdy6=%b want 1 0", err_spur[6], cl_rdy[6]);
    end
    for (int k = 0; k < 4; k++) begin
      do_pop(6, v, g, e);
      vectors++;
      if ({v, g} !== {1'b1, e}) begin
        miscompares++;
        $display("FAIL spur_drop%0d: vld=%b entry=%h want 1 %h", k, v, g, e);
      end
    end
    vectors++;
    if (o_vld[6] !== 1'b0) begin
      miscompares++;
      $display("FAIL spur_dropped: o_vld6=%b want 0", o_vld[6]);
    end
  endtask

  task automatic test_mem_ready();
    logic v; logic [EW-1:0] g, e;
    issue_n(1, 2);
    mem_ready = 1'b0;
    cl_read = '1;
    #1;
    vectors++;
    if (cl_rdy !== '0 || read !== '0) begin
      miscompares++;
      $display("FAIL memrdy_block: cl_rdy=%h read=%h want 00 00", cl_rdy, read);
    end
    drv_ret(1, 64'h1111, 1'b0, 1'b1, 15'h111, 1); tick();
    drv_ret(1, 64'h1112, 1'b1, 1'b0, 15'h112, 1); tick();
    clr_ret();
    for (int k = 0; k < 2; k++) begin
      do_pop(1, v, g, e);
      vectors++;
      if ({v, g} !== {1'b1, e}) begin
        miscompares++;
        $display("FAIL memrdy_drain%0d: vld=%b entry=%h want 1 %h", k, v, g, e);
      end
    end
    cl_read = '0;
    mem_ready = 1'b1;
    #1;
    vectors++;
    if (cl_rdy !== 8'hFF || o_vld !== '0) begin
      miscompares++;
      $display("FAIL memrdy_resume: cl_rdy=%h o_vld=%h want ff 00", cl_rdy, o_vld);
    end
  endtask

  task automatic test_async_reset();
    drv_ret(2, 64'h2222, 1'b1, 1'b1, 15'h222, 0);
    tick();
    clr_ret();
    #2;
    rst = 1'b0;
    #1;
    vectors++;
    if (err_spur !== '0 || o_vld !== '0 || o_dout !== '0) begin
      miscompares++;
      $display("FAIL async_reset: err_spur=%h o_vld=%h want 00 00", err_spur, o_vld);
    end
    @(negedge clk) rst = 1'b1;
    tick();
  endtask

`ifdef ALGO_RDBUF_ECCCNT_EN
  task automatic test_ecccnt();
    vectors++;
    if (serr_cnt !== 16'h0 || derr_cnt !== 16'h0) begin
      miscompares++;
      $display("FAIL ecc_reset: serr=%h derr=%h want 0 0", serr_cnt, derr_cnt);
    end
    rd_vld = '1; rd_serr = '1; rd_derr = 8'h01;
    for (int k = 0; k < 10; k++) tick();
    vectors++;
    if (serr_cnt !== 16'd80 || derr_cnt !== 16'd10) begin
      miscompares++;
      $display("FAIL ecc_count: serr=%0d derr=%0d want 80 10", serr_cnt, derr_cnt);
    end
    for (int k = 10; k < 8200; k++) tick();
    clr_ret();
    vectors++;
    if (serr_cnt !== 16'hFFFF || derr_cnt !== 16'd8200) begin
      miscompares++;
      $display("FAIL ecc_saturate: serr=%h derr=%0d want ffff 8200", serr_cnt, derr_cnt);
    end
  endtask
`endif

  initial begin
    repeat (2) @(posedge clk);
    test_reset();
    test_credit();
    test_back_to_back();
    test_spurious();
    test_mem_ready();
    test_async_reset();
`ifdef ALGO_RDBUF_ECCCNT_EN
    test_ecccnt();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
